button_event_classifier: RTL and testbench

- Sits directly downstream of the debouncer; consumes its clean, debounced button level (`out`).
- Converts that level into single-cycle event pulses: short press, long press, auto-repeat while held, and optionally double-click.
- Feeds the audio processor control logic (volume/mode stepping).
- Runs in a single 50 MHz clock domain.

---
 rtl/button_event_classifier.sv | 143 ++++++++++++++
 tb/tb_button_event_classifier.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/button_event_classifier.sv
// Turns a debounced button level into one-cycle short/long/repeat events.
// Define DOUBLE_CLICK_EN to add the double-click window (WAIT_DBL/DBL_HOLD).
module button_event_classifier #(
  parameter int LONG_CYCLES   = 25000000,
  parameter int REPEAT_CYCLES = 5000000,
  parameter int DBL_CYCLES    = 12500000,
  parameter int CNT_W         = 25
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic short_pulse,
  output logic long_pulse,
  output logic repeat_pulse,
  output logic dbl_pulse,
  output logic held
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] PRESSED  = 3'd1;
  localparam logic [2:0] LONG     = 3'd2;
`ifdef DOUBLE_CLICK_EN
  localparam logic [2:0] WAIT_DBL = 3'd3;
  localparam logic [2:0] DBL_HOLD = 3'd4;
  localparam logic [CNT_W-1:0] DBL_LAST = CNT_W'(DBL_CYCLES - 1);
`endif

  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

  localparam longint MAX_CYCLES =
    64'((LONG_CYCLES > REPEAT_CYCLES)
        ? ((LONG_CYCLES > DBL_CYCLES) ? LONG_CYCLES : DBL_CYCLES)
        : ((REPEAT_CYCLES > DBL_CYCLES) ? REPEAT_CYCLES : DBL_CYCLES));

  // Reject configurations whose terminal counts cannot be represented.
  if (LONG_CYCLES < 2 || REPEAT_CYCLES < 2 ||
      (MAX_CYCLES - 64'sd1) >= (64'sd1 <<< CNT_W)) begin : g_bad_cfg
    $error("button_event_classifier: invalid cycle parameters for CNT_W");
  end

  logic [2:0]       state, state_nxt;
  logic [CNT_W-1:0] count, count_nxt;
  logic             armed;
  logic             short_nxt, long_nxt, repeat_nxt, dbl_nxt, held_nxt;

  always_comb begin
    state_nxt  = state;
    count_nxt  = count;
    short_nxt  = 1'b0;
    long_nxt   = 1'b0;
    repeat_nxt = 1'b0;
    dbl_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (btn && armed) begin
          state_nxt = PRESSED;
          count_nxt = '0;
        end
      end
      // Release wins over the long-press terminal count on the same edge.
      PRESSED: begin
        if (!btn) begin
`ifdef DOUBLE_CLICK_EN
          state_nxt = WAIT_DBL;
`else
          state_nxt = IDLE;
          short_nxt = 1'b1;
`endif
          count_nxt = '0;
        end else if (count == LONG_LAST) begin
          state_nxt = LONG;
          long_nxt  = 1'b1;
          count_nxt = '0;
        end else begin
          count_nxt = count + 1'b1;
        end
      end
      LONG: begin
        if (!btn) begin
          state_nxt = IDLE;
          count_nxt = '0;
        end else if (count == REPEAT_LAST) begin
          repeat_nxt = 1'b1;
          count_nxt  = '0;
        end else begin
          count_nxt = count + 1'b1;
        end
      end
`ifdef DOUBLE_CLICK_EN
      // A second press wins over window expiry on the same edge.
      WAIT_DBL: begin
        if (btn) begin
          state_nxt = DBL_HOLD;
          dbl_nxt   = 1'b1;
          count_nxt = '0;
        end else if (count == DBL_LAST) begin
          state_nxt = IDLE;
          short_nxt = 1'b1;
          count_nxt = '0;
        end else begin
          count_nxt = count + 1'b1;
        end
      end
      DBL_HOLD: begin
        if (!btn) begin
          state_nxt = IDLE;
          count_nxt = '0;
        end
      end
`endif
      default: begin
        state_nxt = IDLE;
        count_nxt = '0;
      end
    endcase
    held_nxt = (state_nxt == PRESSED) || (state_nxt == LONG);
  end

  // A level held through reset stays ignored until the button is seen released.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      count        <= '0;
      armed        <= 1'b0;
      short_pulse  <= 1'b0;
      long_pulse   <= 1'b0;
      repeat_pulse <= 1'b0;
      dbl_pulse    <= 1'b0;
      held         <= 1'b0;
    end else begin
      state        <= state_nxt;
      count        <= count_nxt;
      armed        <= armed | ~btn;
      short_pulse  <= short_nxt;
      long_pulse   <= long_nxt;
      repeat_pulse <= repeat_nxt;
      dbl_pulse    <= dbl_nxt;
      held         <= held_nxt;
    end
  end

endmodule

// File: tb/tb_button_event_classifier.sv
// Table-driven bench for button_event_classifier with short test timings.
module tb_button_event_classifier;

  typedef struct {
    logic       rst;
    logic       btn;
    logic [4:0] exp;
  } vec_t;

  // Expected output vector layout: {short, long, repeat, dbl, held}
  localparam logic [4:0] E_NONE  = 5'b00000;
  localparam logic [4:0] E_HELD  = 5'b00001;
  localparam logic [4:0] E_SHORT = 5'b10000;
  localparam logic [4:0] E_LONG  = 5'b01001;
  localparam logic [4:0] E_REP   = 5'b00101;
  localparam logic [4:0] E_DBL   = 5'b00010;

  logic clk = 1'b0;
  logic reset;
  logic btn;
  logic short_pulse, long_pulse, repeat_pulse, dbl_pulse, held;

  int compared = 0;
  int mismatched = 0;
  vec_t vecs[$];

  button_event_classifier #(
    .LONG_CYCLES  (8),
    .REPEAT_CYCLES(4),
    .DBL_CYCLES   (6),
    .CNT_W        (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .btn         (btn),
    .short_pulse (short_pulse),
    .long_pulse  (long_pulse),
    .repeat_pulse(repeat_pulse),
    .dbl_pulse   (dbl_pulse),
    .held        (held)
  );

  always #5 clk = ~clk;

  task automatic push(input logic r, input logic b, input int n, input logic [4:0] e);
    for (int k = 0; k < n; k++) vecs.push_back('{rst: r, btn: b, exp: e});
  endtask

  // Release row of a short press; with double-click the pulse waits out the window.
  task automatic push_short();
`ifdef DOUBLE_CLICK_EN
    push(1'b0, 1'b0, 6, E_NONE);
    push(1'b0, 1'b0, 1, E_SHORT);
`else
    push(1'b0, 1'b0, 1, E_SHORT);
`endif
  endtask

  task automatic check_output(input string name, input int step, input logic [4:0] exp);
    logic [4:0] got;
    got = {short_pulse, long_pulse, repeat_pulse, dbl_pulse, held};
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s step %0d: got {s,l,r,d,h}=%b required %b", name, step, got, exp);
    end
  endtask

  task automatic apply_stimulus(input logic r, input logic b);
    @(negedge clk);
    reset = r;
    btn   = b;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    btn   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_output("reset_state", 0, E_NONE);

    // Short press: 3 cycles held, then release.
    push(1'b0, 1'b0, 2, E_NONE);
    push(1'b0, 1'b1, 3, E_HELD);
    push_short();
    push(1'b0, 1'b0, 2, E_NONE);

    // Long press with three repeats; release from LONG gives nothing.
    push(1'b0, 1'b1, 8, E_HELD);
    push(1'b0, 1'b1, 1, E_LONG);
    for (int k = 0; k < 3; k++) begin
      push(1'b0, 1'b1, 3, E_HELD);
      push(1'b0, 1'b1, 1, E_REP);
    end
    push(1'b0, 1'b1, 3, E_HELD);
    push(1'b0, 1'b0, 3, E_NONE);

    // Release on the same edge the long counter hits terminal.
    push(1'b0, 1'b1, 8, E_HELD);
    push_short();
    push(1'b0, 1'b0, 2, E_NONE);

    // Press held through reset is ignored until a release is seen.
    push(1'b1, 1'b1, 2, E_NONE);
    push(1'b0, 1'b1, 20, E_NONE);
    push(1'b0, 1'b0, 1, E_NONE);
    push(1'b0, 1'b1, 2, E_HELD);
    push_short();
    push(1'b0, 1'b0, 2, E_NONE);

`ifdef DOUBLE_CLICK_EN
    // Double click, then a lone click, then a double click held long.
    push(1'b0, 1'b1, 2, E_HELD);
    push(1'b0, 1'b0, 3, E_NONE);
    push(1'b0, 1'b1, 1, E_DBL);
    push(1'b0, 1'b1, 1, E_NONE);
    push(1'b0, 1'b0, 2, E_NONE);
    push(1'b0, 1'b1, 2, E_HELD);
    push_short();
    push(1'b0, 1'b0, 3, E_NONE);
    push(1'b0, 1'b1, 2, E_HELD);
    push(1'b0, 1'b0, 2, E_NONE);
    push(1'b0, 1'b1, 1, E_DBL);
    push(1'b0, 1'b1, 19, E_NONE);
    push(1'b0, 1'b0, 2, E_NONE);
`endif

    foreach (vecs[i]) begin
      apply_stimulus(vecs[i].rst, vecs[i].btn);
      check_output("table", i, vecs[i].exp);
    end

    // Async reset while in LONG, then rearm behaviour.
    @(negedge clk);
    btn = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check_output("into_long", 0, E_HELD);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_output("async_reset", 0, E_NONE);
    for (int k = 0; k < 10; k++) begin
      apply_stimulus(1'b0, 1'b1);
      check_output("post_reset_hold", k, E_NONE);
    end
    apply_stimulus(1'b0, 1'b0);
    check_output("rearm", 0, E_NONE);
    apply_stimulus(1'b0, 1'b1);
    check_output("rearm_press", 0, E_HELD);
    apply_stimulus(1'b0, 1'b0);
`ifdef DOUBLE_CLICK_EN
    check_output("rearm_release", 0, E_NONE);
`else
    check_output("rearm_release", 0, E_SHORT);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
